// File: rtl/memory_unit.sv
//==============================================================================
// Module      : memory_unit
// Description : 16x8 program/data RAM with MAR/MDR, serviced by control strobes,
//               plus a valid/ready program-load port. Optional control-word
//               checking is enabled with MEM_STRICT_CTRL_CHK_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module memory_unit #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              lma_n,
    input  logic              lmd_n,
    input  logic              ce_n,
    input  logic              lr_n,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_out_en,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              busy,
    output logic              err
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_RUN   = 2'd1,
        S_PROG  = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   r_mar;
    logic [DATA_W-1:0]   r_mdr;
    logic                r_busy;
    logic [DATA_W-1:0]   r_mem [c_DEPTH];

    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [DATA_W-1:0]   w_wdata;

    // Single write port shared by the clear sweep, lr_n stores and program beats.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        case (r_state)
            S_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_cnt;
            end
            S_RUN: begin
                w_we    = ~lr_n;
                w_waddr = r_mar;
                w_wdata = r_mdr;
            end
            S_PROG: begin
                w_we    = prog_valid;
                w_waddr = prog_addr;
                w_wdata = prog_data;
            end
            default: ;
        endcase
    end

    // RAM is not reset; writes are suppressed while rst is held.
    always_ff @(posedge clk) begin
        if (w_we && !rst)
            r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_mar   <= '0;
            r_mdr   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (&r_cnt) begin
                        r_busy  <= 1'b0;
                        r_state <= prog_mode ? S_PROG : S_RUN;
                    end
                end
                S_RUN: begin
                    if (!lma_n)
                        r_mar <= bus_in[ADDR_W-1:0];
                    if (!lmd_n)
                        r_mdr <= bus_in;
                    if (prog_mode)
                        r_state <= S_PROG;
                end
                S_PROG: begin
                    if (!prog_mode)
                        r_state <= S_RUN;
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    assign bus_out    = r_mem[r_mar];
    assign bus_out_en = (r_state == S_RUN) && !ce_n;
    assign prog_ready = (r_state == S_PROG);
    assign busy       = r_busy;

`ifdef MEM_STRICT_CTRL_CHK_EN
    logic r_err;
    logic w_any_strobe;
    logic w_bad;

    assign w_any_strobe = !lma_n || !lmd_n || !ce_n || !lr_n;
    assign w_bad = (!ce_n && !lr_n)
                || ((r_state != S_RUN) && w_any_strobe)
                || (prog_valid && (r_state != S_PROG));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err <= 1'b0;
        else if (w_bad)
            r_err <= 1'b1;
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_memory_unit.sv
//==============================================================================
// Module      : tb_memory_unit
// Description : Scoreboard bench for memory_unit against a behavioural model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_memory_unit;

    localparam int c_AW    = 4;
    localparam int c_DW    = 8;
    localparam int c_DEPTH = 16;

    localparam int M_CLEAR = 0;
    localparam int M_RUN   = 1;
    localparam int M_PROG  = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [c_DW-1:0] bus_in = '0;
    logic            lma_n = 1'b1, lmd_n = 1'b1, ce_n = 1'b1, lr_n = 1'b1;
    logic [c_DW-1:0] bus_out;
    logic            bus_out_en;
    logic            prog_mode = 1'b0, prog_valid = 1'b0;
    logic [c_AW-1:0] prog_addr = '0;
    logic [c_DW-1:0] prog_data = '0;
    logic            prog_ready, busy, err;

    memory_unit #(.ADDR_W(c_AW), .DATA_W(c_DW)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in),
        .lma_n(lma_n), .lmd_n(lmd_n), .ce_n(ce_n), .lr_n(lr_n),
        .bus_out(bus_out), .bus_out_en(bus_out_en),
        .prog_mode(prog_mode), .prog_valid(prog_valid),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_ready(prog_ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [c_DW-1:0] m_mem [c_DEPTH];
    int              m_mode;
    int              m_sweep;
    int              m_mar;
    logic [c_DW-1:0] m_mdr;
    logic            m_err;

    typedef struct packed {
        logic            en;
        logic [c_DW-1:0] data;
        logic            busy;
        logic            ready;
        logic            err;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [c_DW-1:0] act, input logic [c_DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: consumes one expectation per cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("bus_out_en", {7'd0, bus_out_en}, {7'd0, e.en});
            if (e.en)
                chk("bus_out", bus_out, e.data);
            chk("busy", {7'd0, busy}, {7'd0, e.busy});
            chk("prog_ready", {7'd0, prog_ready}, {7'd0, e.ready});
            chk("err", {7'd0, err}, {7'd0, e.err});
        end
    end

    task automatic model_reset();
        m_mode  = M_CLEAR;
        m_sweep = 0;
        m_mar   = 0;
        m_mdr   = '0;
        m_err   = 1'b0;
    endtask

    task automatic model_edge();
        int  old_mode;
        bit  any_strobe;
        old_mode   = m_mode;
        any_strobe = !lma_n || !lmd_n || !ce_n || !lr_n;
`ifdef MEM_STRICT_CTRL_CHK_EN
        if ((!ce_n && !lr_n) || (old_mode != M_RUN && any_strobe) ||
            (prog_valid && old_mode != M_PROG))
            m_err = 1'b1;
`else
        if (any_strobe) m_err = 1'b0;
`endif
        case (old_mode)
            M_CLEAR: begin
                m_mem[m_sweep] = '0;
                m_sweep++;
                if (m_sweep == c_DEPTH) begin
                    m_sweep = 0;
                    m_mode  = prog_mode ? M_PROG : M_RUN;
                end
            end
            M_RUN: begin
                if (!lr_n) m_mem[m_mar] = m_mdr;
                if (!lma_n) m_mar = int'(bus_in) % c_DEPTH;
                if (!lmd_n) m_mdr = bus_in;
                if (prog_mode) m_mode = M_PROG;
            end
            default: begin
                if (prog_valid) m_mem[prog_addr] = prog_data;
                if (!prog_mode) m_mode = M_RUN;
            end
        endcase
    endtask

    // Called just after a posedge with inputs already set for this cycle.
    task automatic tick();
        exp_t e;
        if (rst) model_reset();
        e.en    = (m_mode == M_RUN) && !ce_n;
        e.data  = m_mem[m_mar];
        e.busy  = (m_mode == M_CLEAR);
        e.ready = (m_mode == M_PROG);
        e.err   = m_err;
        q.push_back(e);
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        lma_n = 1'b1; lmd_n = 1'b1; ce_n = 1'b1; lr_n = 1'b1;
        prog_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (c_DEPTH) tick();
    endtask

    task automatic op(input logic a, input logic d, input logic c, input logic w, input logic [7:0] b);
        lma_n = a; lmd_n = d; ce_n = c; lr_n = w; bus_in = b;
        tick();
        idle_inputs();
    endtask

    task automatic beat(input logic [3:0] a, input logic [7:0] d);
        prog_valid = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < c_DEPTH; i++) m_mem[i] = 'x;
        #100000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk); #1;
        do_reset();

        // Preload RAM[5] then check the sweep clears it.
        prog_mode = 1'b1; tick();
        beat(4'd5, 8'hAB);
        prog_mode = 1'b0; tick();
        op(0, 1, 1, 1, 8'h05);
        op(1, 1, 0, 1, 8'h00);
        do_reset();
        op(0, 1, 1, 1, 8'h05);
        op(1, 1, 0, 1, 8'h00);

        // Program load and upper-bit truncation of MAR.
        prog_mode = 1'b1; tick();
        beat(4'd0, 8'h42);
        beat(4'd1, 8'h2E);
        prog_mode = 1'b0;
        beat(4'd15, 8'h7F);
        op(0, 1, 1, 1, 8'hF1);
        op(1, 1, 0, 1, 8'h00);
        op(0, 1, 0, 1, 8'h0F);
        op(1, 1, 0, 1, 8'h00);

        // STA sequence.
        op(0, 1, 1, 1, 8'h09);
        op(1, 0, 1, 1, 8'h5A);
        op(1, 1, 1, 0, 8'h00);
        op(1, 1, 0, 1, 8'h00);

        // Same-edge ordering: write uses old MAR/MDR.
        op(0, 1, 1, 1, 8'h07);
        op(1, 1, 0, 1, 8'h00);
        op(0, 0, 1, 1, 8'h03);
        op(1, 0, 1, 1, 8'h11);
        op(0, 1, 0, 0, 8'h07);
        op(1, 1, 0, 1, 8'h00);
        op(0, 1, 0, 1, 8'h03);

        // Mode isolation in PROG.
        prog_mode = 1'b1; tick();
        op(1, 1, 0, 0, 8'h00);
        prog_mode = 1'b0; tick();
        op(1, 1, 0, 1, 8'h00);
        repeat (3) tick();

        // Reset while a beat is in flight.
        op(0, 1, 1, 1, 8'h04);
        prog_mode = 1'b1; tick();
        prog_valid = 1'b1; prog_addr = 4'd4; prog_data = 8'h99;
        rst = 1'b1;
        tick();
        prog_valid = 1'b0; rst = 1'b0; prog_mode = 1'b0;
        repeat (c_DEPTH) tick();
        op(0, 1, 1, 1, 8'h04);
        op(1, 1, 0, 1, 8'h00);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 15) == 0) prog_mode = ~prog_mode;
                lma_n      = ($urandom_range(0, 3) != 0);
                lmd_n      = ($urandom_range(0, 3) != 0);
                ce_n       = ($urandom_range(0, 1) != 0);
                lr_n       = ($urandom_range(0, 4) != 0);
                bus_in     = 8'($urandom);
                prog_valid = ($urandom_range(0, 1) != 0);
                prog_addr  = 4'($urandom);
                prog_data  = 8'($urandom);
                tick();
                idle_inputs();
            end
        end
        prog_mode = 1'b0;
        repeat (2) tick();
        @(negedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
